// File: rtl/serial_link_pkg.sv
// Shared definitions for the 2-bit-per-cycle serial link, used by both the
// word serializer (sender) and serial_recv (receiver).
package serial_link_pkg;

  localparam int WORD_W         = 64;
  localparam int PAIRS_PER_WORD = 32;
  localparam int CNT_W          = $clog2(PAIRS_PER_WORD);

  localparam logic [WORD_W-1:0] SYNC_WORD_DEFAULT = 64'hD5A3_0F96_3C5A_E71B;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } recv_state_e;

  // Data-word counter width: enough to reach the sync interval, never zero.
  function automatic int wcnt_width(input int interval);
    return (interval > 0) ? $clog2(interval + 1) : 1;
  endfunction

endpackage

// File: rtl/serial_recv_align.sv
// Bit-pair window and sync-word comparators for serial_recv.
// The odd-phase comparator is enabled by SERIAL_RECV_BITSLIP_EN.
module serial_recv_align
  import serial_link_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_din,
  input  logic              i_slip,
  output logic              o_match_even,
  output logic              o_match_odd,
  output logic [WORD_W-1:0] o_word
);

  // One extra bit so a word straddling the pair boundary is also visible.
  logic [WORD_W:0] r_win;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_win <= '0;
    end else begin
      r_win <= {r_win[WORD_W-2:0], i_din};
    end
  end

  assign o_match_even = (r_win[WORD_W-1:0] == SYNC_WORD);

`ifdef SERIAL_RECV_BITSLIP_EN
  assign o_match_odd = (r_win[WORD_W:1] == SYNC_WORD);
`else
  assign o_match_odd = 1'b0;
`endif

  assign o_word = i_slip ? r_win[WORD_W:1] : r_win[WORD_W-1:0];

endmodule

// File: rtl/serial_recv.sv
// Serial link receiver: hunts for the sync word, then emits aligned 64-bit
// words every 32 pairs. Optional odd-phase lock via SERIAL_RECV_BITSLIP_EN.
module serial_recv
  import serial_link_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int                SYNC_INTERVAL = 16
) (
  input  logic              CLKS,
  input  logic              RSTS,
  input  logic [1:0]        DIN,
  input  logic              RESYNC,
  output logic [WORD_W-1:0] DOUT,
  output logic              VALID,
  output logic              LOCK,
  output logic              SYNC_ERR
);

  localparam int                WCNT_W     = wcnt_width(SYNC_INTERVAL);
  localparam bit                SYNC_CHECK = (SYNC_INTERVAL > 0);
  localparam logic [WCNT_W-1:0] WCNT_SYNC  = WCNT_W'(SYNC_INTERVAL);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PAIRS_PER_WORD - 1);

  recv_state_e       r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_next;
  logic              r_slip, w_slip_next;
  logic [WORD_W-1:0] r_dout, w_dout_next;
  logic              r_valid, w_valid_next;
  logic              r_lock, w_lock_next;
  logic              r_sync_err, w_sync_err_next;

  logic              w_match_even;
  logic              w_match_odd;
  logic [WORD_W-1:0] w_word;
  logic              w_sync_due;
  logic              w_sync_ok;

  serial_recv_align #(
    .SYNC_WORD (SYNC_WORD)
  ) u_align (
    .i_clk        (CLKS),
    .i_rst        (RSTS),
    .i_din        (DIN),
    .i_slip       (r_slip),
    .o_match_even (w_match_even),
    .o_match_odd  (w_match_odd),
    .o_word       (w_word)
  );

  assign w_sync_due = SYNC_CHECK && (r_wcnt == WCNT_SYNC);
  assign w_sync_ok  = r_slip ? w_match_odd : w_match_even;

  always_ff @(posedge CLKS or posedge RSTS) begin
    if (RSTS) begin
      r_state    <= HUNT;
      r_cnt      <= '0;
      r_wcnt     <= '0;
      r_slip     <= 1'b0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_lock     <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_wcnt     <= w_wcnt_next;
      r_slip     <= w_slip_next;
      r_dout     <= w_dout_next;
      r_valid    <= w_valid_next;
      r_lock     <= w_lock_next;
      r_sync_err <= w_sync_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_wcnt_next     = r_wcnt;
    w_slip_next     = r_slip;
    w_dout_next     = r_dout;
    w_valid_next    = 1'b0;
    w_lock_next     = r_lock;
    w_sync_err_next = 1'b0;

    case (r_state)
      HUNT: begin
        w_cnt_next  = '0;
        w_wcnt_next = '0;
        // RESYNC has no effect here; a match always wins.
        if (w_match_even || w_match_odd) begin
          w_state_next = LOCKED;
          w_lock_next  = 1'b1;
`ifdef SERIAL_RECV_BITSLIP_EN
          w_slip_next  = ~w_match_even;
`else
          w_slip_next  = 1'b0;
`endif
        end
      end

      LOCKED: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (RESYNC) begin
          w_state_next = HUNT;
          w_lock_next  = 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          if (w_sync_due) begin
            if (w_sync_ok) begin
              w_wcnt_next = '0;
            end else begin
              w_sync_err_next = 1'b1;
              w_state_next    = HUNT;
              w_lock_next     = 1'b0;
            end
          end else begin
            w_dout_next  = w_word;
            w_valid_next = 1'b1;
            w_wcnt_next  = r_wcnt + WCNT_W'(1);
          end
        end
      end

      default: begin
        w_state_next = HUNT;
        w_lock_next  = 1'b0;
      end
    endcase
  end

  assign DOUT     = r_dout;
  assign VALID    = r_valid;
  assign LOCK     = r_lock;
  assign SYNC_ERR = r_sync_err;

endmodule

// File: tb/tb_serial_recv.sv
// Directed self-checking bench for serial_recv (SYNC_INTERVAL=4).
// Odd-phase expectations follow SERIAL_RECV_BITSLIP_EN.
module tb_serial_recv;

  localparam logic [63:0] SYNC = 64'hD5A3_0F96_3C5A_E71B;

  logic        CLKS = 1'b0;
  logic        RSTS = 1'b1;
  logic [1:0]  DIN = 2'b00;
  logic        RESYNC = 1'b0;
  logic [63:0] DOUT;
  logic        VALID;
  logic        LOCK;
  logic        SYNC_ERR;

  serial_recv #(
    .SYNC_WORD     (SYNC),
    .SYNC_INTERVAL (4)
  ) dut (
    .CLKS     (CLKS),
    .RSTS     (RSTS),
    .DIN      (DIN),
    .RESYNC   (RESYNC),
    .DOUT     (DOUT),
    .VALID    (VALID),
    .LOCK     (LOCK),
    .SYNC_ERR (SYNC_ERR)
  );

  always #5 CLKS = ~CLKS;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          v_n, serr_n, rise_n, fall_n;
  int          serr_cyc, rise_cyc, fall_cyc;
  logic [63:0] serr_dout;
  logic        lock_prev;
  int          v_cyc [32];
  logic [63:0] v_dat [32];
  logic [63:0] dw [9];
  bit          bq [$];
  int          e0, e1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    v_n = 0; serr_n = 0; rise_n = 0; fall_n = 0;
    serr_cyc = -1; rise_cyc = -1; fall_cyc = -1; serr_dout = '0;
    lock_prev = LOCK;
    for (int i = 0; i < 32; i++) begin
      v_cyc[i] = -1;
      v_dat[i] = '0;
    end
  endtask

  task automatic step(input logic [1:0] d, input logic rs);
    DIN = d;
    RESYNC = rs;
    @(posedge CLKS);
    #1;
    cyc++;
    RESYNC = 1'b0;
    if (VALID) begin
      $display("cycle %0d: VALID dout=%h", cyc, DOUT);
      if (v_n < 32) begin
        v_cyc[v_n] = cyc;
        v_dat[v_n] = DOUT;
      end
      v_n++;
    end
    if (SYNC_ERR) begin
      $display("cycle %0d: SYNC_ERR", cyc);
      serr_n++; serr_cyc = cyc; serr_dout = DOUT;
    end
    if (LOCK && !lock_prev) begin rise_n++; rise_cyc = cyc; end
    if (!LOCK && lock_prev) begin fall_n++; fall_cyc = cyc; end
    lock_prev = LOCK;
  endtask

  task automatic push_word(input logic [63:0] w);
    for (int i = 63; i >= 0; i--) bq.push_back(w[i]);
  endtask

  task automatic push_bits(input int n, input bit rnd);
    for (int i = 0; i < n; i++) bq.push_back(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  // Send pairs from the bit queue, earliest bit on DIN[1]; RESYNC on the first pair if rs.
  task automatic flush_n(input bit rs, input int n);
    bit b1, b0, first;
    first = rs;
    for (int k = 0; k < n && bq.size() >= 2; k++) begin
      b1 = bq.pop_front();
      b0 = bq.pop_front();
      step({b1, b0}, first);
      first = 1'b0;
    end
  endtask

  task automatic send_word(input logic [63:0] w);
    push_word(w);
    flush_n(1'b0, 1000);
  endtask

  task automatic do_reset();
    RSTS = 1'b1;
    bq.delete();
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);
    RSTS = 1'b0;
    clear_log();
  endtask

  initial begin
    dw[0] = 64'h0123_4567_89AB_CDEF; dw[1] = 64'hFEDC_BA98_7654_3210;
    dw[2] = 64'hA5A5_5A5A_0000_FFFF; dw[3] = 64'h1111_2222_3333_4444;
    dw[4] = 64'hDEAD_BEEF_CAFE_F00D; dw[5] = 64'h8000_0000_0000_0001;
    dw[6] = 64'h7FFF_FFFF_FFFF_FFFE; dw[7] = 64'h0F0F_F0F0_3C3C_C3C3;
    dw[8] = 64'h5555_AAAA_1234_5678;

    // Reset state
    step(2'b00, 1'b0);
    step(2'b11, 1'b0);
    check("rst_dout", DOUT, 64'd0);
    check("rst_valid", {63'd0, VALID}, 64'd0);
    check("rst_lock", {63'd0, LOCK}, 64'd0);
    check("rst_serr", {63'd0, SYNC_ERR}, 64'd0);

    // Acquisition, first-word latency, and a full sync interval with a good re-sync
    do_reset();
    push_bits(6, 1'b0); flush_n(1'b0, 1000);
    send_word(SYNC); e0 = cyc;
    check("t1_lock_at_e0", {63'd0, LOCK}, 64'd0);
    for (int k = 0; k < 4; k++) send_word(dw[k]);
    send_word(SYNC);
    for (int k = 4; k < 8; k++) send_word(dw[k]);
    push_bits(2, 1'b0); flush_n(1'b0, 1000);
    check("t1_lock_rise_cyc", 64'(rise_cyc), 64'(e0 + 1));
    check("t2_valid_count", 64'(v_n), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_valid%0d_cyc", k), 64'(v_cyc[k]), 64'(e0 + 33 + 32 * k + ((k >= 4) ? 32 : 0)));
      check($sformatf("t2_valid%0d_dout", k), v_dat[k], dw[k]);
    end
    check("t2_serr_count", 64'(serr_n), 64'd0);
    check("t2_lock_end", {63'd0, LOCK}, 64'd1);
    check("t2_lock_fall_count", 64'(fall_n), 64'd0);

    // Corrupted second sync word
    do_reset();
    push_bits(6, 1'b0); flush_n(1'b0, 1000);
    send_word(SYNC); e0 = cyc;
    for (int k = 0; k < 4; k++) send_word(dw[k]);
    send_word(SYNC ^ 64'd1);
    for (int k = 4; k < 8; k++) send_word(dw[k]);
    send_word(SYNC); e1 = cyc;
    send_word(dw[8]);
    push_bits(2, 1'b0); flush_n(1'b0, 1000);
    check("t3_serr_count", 64'(serr_n), 64'd1);
    check("t3_serr_cyc", 64'(serr_cyc), 64'(e0 + 161));
    check("t3_lock_fall_cyc", 64'(fall_cyc), 64'(e0 + 161));
    check("t3_dout_held", serr_dout, dw[3]);
    check("t3_valid_count", 64'(v_n), 64'd5);
    check("t3_relock_cyc", 64'(rise_cyc), 64'(e1 + 1));
    check("t3_valid4_cyc", 64'(v_cyc[4]), 64'(e1 + 33));
    check("t3_valid4_dout", v_dat[4], dw[8]);

    // Stream delayed by one bit
    do_reset();
    push_bits(21, 1'b1);
    push_word(SYNC); flush_n(1'b0, 1000);
    e0 = cyc + 1;
    push_word(dw[0]); flush_n(1'b0, 1000);
    push_bits(3, 1'b0); flush_n(1'b0, 1000);
`ifdef SERIAL_RECV_BITSLIP_EN
    check("t4_lock_rise_cyc", 64'(rise_cyc), 64'(e0 + 1));
    check("t4_valid_count", 64'(v_n), 64'd1);
    check("t4_valid_cyc", 64'(v_cyc[0]), 64'(e0 + 33));
    check("t4_valid_dout", v_dat[0], dw[0]);
`else
    check("t4_lock_rise_count", 64'(rise_n), 64'd0);
    check("t4_valid_count", 64'(v_n), 64'd0);
    check("t4_lock_end", {63'd0, LOCK}, 64'd0);
`endif

    // RESYNC on the edge a word is evaluated
    do_reset();
    push_bits(6, 1'b0); flush_n(1'b0, 1000);
    send_word(SYNC); e0 = cyc;
    send_word(dw[0]);
    push_word(dw[1]); flush_n(1'b1, 1000);
    send_word(SYNC); e1 = cyc;
    send_word(dw[2]);
    push_bits(2, 1'b0); flush_n(1'b0, 1000);
    check("t5_lock_fall_cyc", 64'(fall_cyc), 64'(e0 + 33));
    check("t5_serr_count", 64'(serr_n), 64'd0);
    check("t5_valid_count", 64'(v_n), 64'd1);
    check("t5_valid_cyc", 64'(v_cyc[0]), 64'(e1 + 33));
    check("t5_valid_dout", v_dat[0], dw[2]);
    check("t5_lock_end", {63'd0, LOCK}, 64'd1);

    // Asynchronous reset mid-word (cnt=17), then reacquire
    do_reset();
    push_bits(6, 1'b0); flush_n(1'b0, 1000);
    send_word(SYNC); e0 = cyc;
    send_word(dw[0]);
    push_word(dw[1]); flush_n(1'b0, 18);
    check("t6_pre_dout", DOUT, dw[0]);
    check("t6_pre_lock", {63'd0, LOCK}, 64'd1);
    RSTS = 1'b1;
    #2;
    check("t6_rst_dout", DOUT, 64'd0);
    check("t6_rst_lock", {63'd0, LOCK}, 64'd0);
    check("t6_rst_valid", {63'd0, VALID}, 64'd0);
    bq.delete();
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);
    RSTS = 1'b0;
    clear_log();
    push_bits(4, 1'b0); flush_n(1'b0, 1000);
    send_word(SYNC); e1 = cyc;
    send_word(dw[3]);
    push_bits(2, 1'b0); flush_n(1'b0, 1000);
    check("t6_relock_cyc", 64'(rise_cyc), 64'(e1 + 1));
    check("t6_valid_count", 64'(v_n), 64'd1);
    check("t6_valid_cyc", 64'(v_cyc[0]), 64'(e1 + 33));
    check("t6_valid_dout", v_dat[0], dw[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_recv.md
Name: serial_recv

Overview:
- Receive end of the 2-bit-per-cycle serial link; counterpart of the 64-bit word serializer.
- Input is the bit-pair stream already de-DDR'd by the input DDR primitive and the LVDS buffer, in the fast serial clock domain (CLKS).
- Block hunts for a 64-bit sync word to find the word boundary, then outputs aligned 64-bit words to the BER checker.
- Optionally verifies a periodically re-inserted sync word and drops lock on mismatch.

Parameters:
- SYNC_WORD, 64'hD5A3_0F96_3C5A_E71B, framing pattern sent MSB first.
- SYNC_INTERVAL, 16, number of data words between sync words; 0 means the block checks sync only at acquisition.

Ports:
- CLKS  input  1  serial clock; one bit pair per rising edge.
- RSTS  input  1  asynchronous active-high reset.
- DIN  input  2  received bit pair; DIN[1] is the earlier bit in time.
- RESYNC  input  1  single-cycle request to drop lock and re-hunt.
- DOUT  output  64  aligned data word; bit 63 is the first bit received.
- VALID  output  1  one-cycle strobe; DOUT is valid while VALID is high.
- LOCK  output  1  high while in LOCKED.
- SYNC_ERR  output  1  one-cycle pulse on an expected-sync mismatch.

Behaviour:
- Reset values: DOUT=0, VALID=0, LOCK=0, SYNC_ERR=0, window=0, state=HUNT, cnt=0, wcnt=0.
- Window: 65-bit shift register, updated every edge as win <= {win[62:0], DIN[1], DIN[0]}.
  - Even candidate = win[63:0].
  - Odd candidate = win[64:1]; used only with the optional feature.
- cnt: 5-bit phase counter, wraps 31->0.
- wcnt: data-word counter, width ceil(log2(SYNC_INTERVAL+1)), minimum 1.
- HUNT:
  - Every edge, compare the candidate(s) with SYNC_WORD.
  - On a match (even candidate wins if both match): go to LOCKED, cnt<=0, wcnt<=0, latch slip flag (0 = even, 1 = odd).
- LOCKED:
  - cnt increments every edge.
  - Edge E0 denotes the edge at which the sync word became complete in the window. The first data word is complete 32 edges after E0.
  - A word is complete each time cnt==31 at an edge. At the following edge, that word is evaluated:
    - Data word: DOUT <= selected candidate, VALID=1 for one cycle, wcnt increments.
    - Expected sync word: this is the word completing when wcnt==SYNC_INTERVAL, and only applies if SYNC_INTERVAL>0. It is not output (VALID stays 0).
      - Match: wcnt<=0, stay LOCKED.
      - Mismatch: SYNC_ERR=1 for one cycle, state<=HUNT, LOCK<=0.
  - Latency: the first VALID is registered at edge E0+33.
  - Word period: 32 cycles.
  - VALID never asserts in HUNT.
- LOCK is registered. It goes high at the edge entering LOCKED and low at the edge leaving LOCKED.
- RESYNC:
  - Sampled every edge.
  - In LOCKED: go to HUNT next edge, with no VALID or SYNC_ERR that cycle, even if a word completes simultaneously.
  - In HUNT: ignored, and it does not block a match in the same cycle.
- Async reset mid-word: all state is cleared immediately; hunting resumes on the first edge after deassert.
- DOUT holds its last value between VALID strobes and across loss of lock.

Optional Feature:
- SERIAL_RECV_BITSLIP_EN.
  - Defined: HUNT also matches the odd candidate, and LOCKED outputs win[64:1] when slip=1. This covers links where the DDR pair phase is inverted.
  - Undefined: only the even candidate is used. The slip flag is tied to 0, and win[64] may be optimised away.

Decomposition:
- Shared package serial_link_pkg holds:
  - the default SYNC_WORD constant;
  - WORD_W=64 and PAIRS_PER_WORD=32;
  - the recv state enum {HUNT, LOCKED}.
- The sender side picks up the same SYNC_WORD from this package.
- One sub-module, serial_recv_align: window register plus candidate compare; outputs match_even, match_odd and the selected word.
- The FSM and counters stay in serial_recv.

Test Plan:
- Reset, then drive pairs of SYNC_WORD followed by word 64'h0123_4567_89AB_CDEF -> LOCK rises one edge after the sync completes; VALID at E0+33 with DOUT=64'h0123_4567_89AB_CDEF.
- With SYNC_INTERVAL=4: sync, 4 data words, correct sync, 4 words -> 8 VALID strobes spaced 32 cycles apart, SYNC_ERR never asserts, LOCK stays 1.
- Same sequence, but corrupt bit 0 of the second sync -> SYNC_ERR pulses once, LOCK=0, no VALID until the next correct sync is received.
- Random idle data, then the stream delayed by 1 bit -> with the macro: lock with slip=1 and correct DOUT; without the macro: LOCK stays 0.
- RESYNC pulsed while LOCKED on the same edge a word completes -> no VALID that cycle, LOCK=0 next edge, relock on the next sync.
- Assert RSTS at cnt=17 mid-word -> all outputs return to 0 immediately; after release, a normal reacquisition succeeds.
